// File: rtl/paddle_adc_scheduler.sv
// Paddle ADC scheduler: alternates one 7-bit ADC between two paddle pots.
// Optional PADDLE_FILTER_EN enables a per-channel rounding average filter.
module paddle_adc_scheduler #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int START_CYCLES  = 4,
  parameter int CONV_TIMEOUT  = 20000
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] adc_data,
  input  logic       adc_ready,
  output logic       adc_start,
  output logic       mux_sel,
  output logic [7:0] p1_value,
  output logic [7:0] p2_value,
  output logic       p1_valid,
  output logic       p2_valid,
  output logic       timeout_err
);

  localparam int MAXC_A = (SETTLE_CYCLES > START_CYCLES) ? SETTLE_CYCLES : START_CYCLES;
  localparam int MAXC   = (MAXC_A > CONV_TIMEOUT) ? MAXC_A : CONV_TIMEOUT;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STA_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(CONV_TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SELECT = 2'd1;
  localparam logic [1:0] START  = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ch_q, ch_d;
  logic          mux_q, mux_d;
  logic          start_q, start_d;
  logic [7:0]    p1_q, p1_d, p2_q, p2_d;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic          to_q, to_d;
  logic          s1_q, s2_q, s3_q;
  logic          rdy_edge;
  logic [7:0]    raw;
  logic          unused_data7;

  assign unused_data7 = adc_data[7];
  assign raw          = {adc_data[6:0], 1'b0};
  assign rdy_edge     = s2_q & ~s3_q;

`ifdef PADDLE_FILTER_EN
  logic pr1_q, pr1_d, pr2_q, pr2_d;

  // Rounding average, sum kept in 9 bits so 8'hFE + 8'hFE cannot wrap.
  function automatic logic [7:0] upd(input logic [7:0] old,
                                     input logic [7:0] nw,
                                     input logic       primed);
    logic [8:0] sum;
    sum = {1'b0, old} + {1'b0, nw} + 9'd1;
    return primed ? sum[8:1] : nw;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    mux_d   = mux_q;
    start_d = start_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    v1_d    = 1'b0;
    v2_d    = 1'b0;
    to_d    = 1'b0;
`ifdef PADDLE_FILTER_EN
    pr1_d   = pr1_q;
    pr2_d   = pr2_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SELECT;
          cnt_d   = '0;
          mux_d   = ch_q;
        end
      end
      SELECT: begin
        if (cnt_q == SET_LAST) begin
          state_d = START;
          cnt_d   = '0;
          start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        if (cnt_q == STA_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
          start_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // A ready edge beats a simultaneous timeout.
        if (rdy_edge || cnt_q == TO_LAST) begin
          if (rdy_edge) begin
            if (ch_q) begin
`ifdef PADDLE_FILTER_EN
              p2_d  = upd(p2_q, raw, pr2_q);
              pr2_d = 1'b1;
`else
              p2_d  = raw;
`endif
              v2_d  = 1'b1;
            end else begin
`ifdef PADDLE_FILTER_EN
              p1_d  = upd(p1_q, raw, pr1_q);
              pr1_d = 1'b1;
`else
              p1_d  = raw;
`endif
              v1_d  = 1'b1;
            end
          end else begin
            to_d = 1'b1;
          end
          ch_d  = ~ch_q;
          cnt_d = '0;
          if (enable) begin
            state_d = SELECT;
            mux_d   = ~ch_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= 1'b0;
      mux_q   <= 1'b0;
      start_q <= 1'b0;
      p1_q    <= 8'h00;
      p2_q    <= 8'h00;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      to_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      mux_q   <= mux_d;
      start_q <= start_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      to_q    <= to_d;
      s1_q    <= adc_ready;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

`ifdef PADDLE_FILTER_EN
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pr1_q <= 1'b0;
      pr2_q <= 1'b0;
    end else begin
      pr1_q <= pr1_d;
      pr2_q <= pr2_d;
    end
  end
`endif

  assign adc_start   = start_q;
  assign mux_sel     = mux_q;
  assign p1_value    = p1_q;
  assign p2_value    = p2_q;
  assign p1_valid    = v1_q;
  assign p2_valid    = v2_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_paddle_adc_scheduler.sv
// Scoreboard bench for paddle_adc_scheduler (SETTLE=4, START=2, TIMEOUT=16).
// Expected captures/timeouts are queued by stimulus and checked by a monitor.
module tb_paddle_adc_scheduler;

  localparam int S  = 4;
  localparam int ST = 2;
  localparam int T  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       rdy = 1'b0;
  logic       adc_start, mux_sel, p1_valid, p2_valid, timeout_err;
  logic [7:0] p1_value, p2_value;

  paddle_adc_scheduler #(
    .SETTLE_CYCLES(S),
    .START_CYCLES (ST),
    .CONV_TIMEOUT (T)
  ) dut (
    .sys_clk    (clk),
    .reset_n    (rst_n),
    .enable     (en),
    .adc_data   (data),
    .adc_ready  (rdy),
    .adc_start  (adc_start),
    .mux_sel    (mux_sel),
    .p1_value   (p1_value),
    .p2_value   (p2_value),
    .p1_valid   (p1_valid),
    .p2_valid   (p2_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ch;
    logic       to;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (p1_valid || p2_valid || timeout_err)) begin
      exp_t e;
      check("onehot", int'(p1_valid) + int'(p2_valid) + int'(timeout_err), 1);
      if (q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = q.pop_front();
        check("event_kind",
              {29'd0, timeout_err, p2_valid, p1_valid},
              e.to ? 4 : (e.ch ? 2 : 1));
        check(e.ch ? "p2_value" : "p1_value",
              int'(e.ch ? p2_value : p1_value), int'(e.val));
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_slot(input logic ch, input bit respond, input int d,
                         input logic [6:0] d7, input logic [7:0] ev,
                         input bit drop);
    int n;
    int w;
    int f;
    exp_t e;
    n = 0;
    while (!adc_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", int'(adc_start), 1);
    if (!adc_start) return;
    check("mux_sel", int'(mux_sel), int'(ch));
    if (drop) en = 1'b0;
    w = 0;
    while (adc_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("start_width", w, ST);
    f = cyc;
    e.ch = ch;
    e.val = ev;
    if (respond) begin
      repeat (d) @(posedge clk);
      #1;
      data = {1'b1, d7};
      rdy = 1'b1;
      e.to = 1'b0;
      e.cyc = cyc + 3;
      q.push_back(e);
      repeat (4) @(posedge clk);
      #1 rdy = 1'b0;
    end else begin
      e.to = 1'b1;
      e.cyc = f + T;
      q.push_back(e);
      repeat (T + 1) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] f_tie, f_s5, f_s6, f_last;
`ifdef PADDLE_FILTER_EN
    f_tie  = 8'h3A;
    f_s5   = 8'h56;
    f_s6   = 8'h9C;
    f_last = 8'h7F;
`else
    f_tie  = 8'h20;
    f_s5   = 8'h02;
    f_s6   = 8'hFE;
    f_last = 8'h00;
`endif
    // Reset held while the ADC pins wiggle.
    repeat (5) begin
      @(negedge clk);
      rdy  = ~rdy;
      data = data + 8'h37;
    end
    check("reset_outputs",
          int'({adc_start, mux_sel, p1_value, p2_value,
                p1_valid, p2_valid, timeout_err}), 0);
    rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (adc_start) bad++;
    end
    check("idle_no_start", bad, 0);

    en = 1'b1;
    do_slot(1'b0, 1, 3,  7'h55, 8'hAA, 0);
    do_slot(1'b1, 1, 3,  7'h2A, 8'h54, 0);
    do_slot(1'b0, 0, 0,  7'h00, 8'hAA, 0);
    do_slot(1'b1, 1, 13, 7'h10, f_tie, 0);
    do_slot(1'b0, 1, 3,  7'h01, f_s5,  0);
    do_slot(1'b1, 1, 3,  7'h7F, f_s6,  1);

    // Parked in IDLE with the last channel on the mux.
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (adc_start || !mux_sel) bad++;
    end
    check("idle_after_drop", bad, 0);
    check("queue_drained", q.size(), 0);
    en = 1'b1;

    // Reset in the middle of a start pulse.
    bad = 0;
    while (!adc_start && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    check("pre_reset_mux", int'(mux_sel), 0);
    rst_n = 1'b0;
    #1;
    check("async_start_drop", int'(adc_start), 0);
    check("reset_values",
          int'({mux_sel, p1_value, p2_value, p1_valid, p2_valid}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_slot(1'b0, 1, 3, 7'h7F, 8'hFE, 0);
    do_slot(1'b1, 1, 3, 7'h00, 8'h00, 0);
    do_slot(1'b0, 1, 3, 7'h00, f_last, 1);

    repeat (10) @(negedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
